// File: rtl/cmos_dvp_pkg.sv
// Shared DVP definitions: FSM states, RGB565 layout, byte-order helpers and blanking defaults.
// Used by both the transmit (sensor emulator) and receive (capture) sides.
package cmos_dvp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVbp,
    StActive,
    StHblank,
    StVfp
  } dvp_state_e;

  localparam int unsigned RWidth    = 5;
  localparam int unsigned GWidth    = 6;
  localparam int unsigned BWidth    = 5;
  localparam int unsigned PixWidth  = RWidth + GWidth + BWidth;
  localparam int unsigned ByteWidth = 8;

  typedef struct packed {
    logic [RWidth-1:0] r;
    logic [GWidth-1:0] g;
    logic [BWidth-1:0] b;
  } rgb565_t;

  localparam int unsigned DefVsClks  = 16;
  localparam int unsigned DefVbpClks = 64;
  localparam int unsigned DefHbClks  = 32;
  localparam int unsigned DefVfpClks = 64;

  // OV5640 order: high byte goes on the bus first.
  function automatic logic [ByteWidth-1:0] pix_hi(input logic [PixWidth-1:0] pix);
    return pix[PixWidth-1 -: ByteWidth];
  endfunction

  function automatic logic [ByteWidth-1:0] pix_lo(input logic [PixWidth-1:0] pix);
    return pix[ByteWidth-1:0];
  endfunction

  function automatic logic [PixWidth-1:0] pix_join(input logic [ByteWidth-1:0] first_byte,
                                                  input logic [ByteWidth-1:0] second_byte);
    return {first_byte, second_byte};
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmos_dvp_timing.sv
// Frame/line sequencer for the DVP transmitter: walks vsync, back porch, active lines,
// line blanking and front porch, and exposes the state plus counter phase flags.
module cmos_dvp_timing
  import cmos_dvp_pkg::*;
#(
  parameter int unsigned H_PIXEL  = 1024,
  parameter int unsigned V_PIXEL  = 768,
  parameter int unsigned VS_CLKS  = DefVsClks,
  parameter int unsigned VBP_CLKS = DefVbpClks,
  parameter int unsigned HB_CLKS  = DefHbClks,
  parameter int unsigned VFP_CLKS = DefVfpClks
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  output dvp_state_e state_o,
  output logic       first_o,
  output logic       last_o,
  output logic       odd_o
);

  localparam int unsigned CntMax = max2(max2(VS_CLKS, VBP_CLKS),
                                        max2(max2(HB_CLKS, VFP_CLKS), 2 * H_PIXEL));
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned LineW  = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;

  localparam logic [CntW-1:0]  VsLast   = CntW'(VS_CLKS - 1);
  localparam logic [CntW-1:0]  VbpLast  = CntW'(VBP_CLKS - 1);
  localparam logic [CntW-1:0]  ActLast  = CntW'(2 * H_PIXEL - 1);
  localparam logic [CntW-1:0]  HbLast   = CntW'(HB_CLKS - 1);
  localparam logic [CntW-1:0]  VfpLast  = CntW'(VFP_CLKS - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(V_PIXEL - 1);

  dvp_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LineW-1:0] line_q, line_d;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StVsync:  last = (cnt_q == VsLast);
      StVbp:    last = (cnt_q == VbpLast);
      StActive: last = (cnt_q == ActLast);
      StHblank: last = (cnt_q == HbLast);
      StVfp:    last = (cnt_q == VfpLast);
      default:  last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable_i) state_d = StVsync;
      end
      StVsync: begin
        if (last) begin
          state_d = StVbp;
          cnt_d   = '0;
        end
      end
      StVbp: begin
        if (last) begin
          state_d = StActive;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      StActive: begin
        if (last) begin
          state_d = StHblank;
          cnt_d   = '0;
        end
      end
      StHblank: begin
        if (last) begin
          cnt_d = '0;
          if (line_q == LineLast) begin
            state_d = StVfp;
          end else begin
            state_d = StActive;
            line_d  = line_q + 1'b1;
          end
        end
      end
      StVfp: begin
        if (last) begin
          cnt_d   = '0;
          // Enable is only honoured at frame boundaries so frames are never truncated.
          state_d = enable_i ? StVsync : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign first_o = (cnt_q == '0);
  assign last_o  = last;
  assign odd_o   = cnt_q[0];

endmodule

// File: rtl/cmos_dvp_tx.sv
// Camera-side DVP transmitter: serialises valid/ready RGB565 pixels into OV5640-style
// vsync/href/byte traffic, high byte first. Outputs lag the sequencer state by one clock.
module cmos_dvp_tx
  import cmos_dvp_pkg::*;
#(
  parameter int unsigned H_PIXEL  = 1024,
  parameter int unsigned V_PIXEL  = 768,
  parameter int unsigned VS_CLKS  = DefVsClks,
  parameter int unsigned VBP_CLKS = DefVbpClks,
  parameter int unsigned HB_CLKS  = DefHbClks,
  parameter int unsigned VFP_CLKS = DefVfpClks
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pix_valid,
  input  logic [PixWidth-1:0]  pix_data,
  output logic                 pix_ready,
  output logic                 pix_sof,
  output logic                 dvp_vsync,
  output logic                 dvp_href,
  output logic [ByteWidth-1:0] dvp_data,
  output logic                 frame_done,
  output logic                 underrun
);

  dvp_state_e state;
  logic       cnt_first, cnt_last, cnt_odd;

  cmos_dvp_timing #(
    .H_PIXEL  (H_PIXEL),
    .V_PIXEL  (V_PIXEL),
    .VS_CLKS  (VS_CLKS),
    .VBP_CLKS (VBP_CLKS),
    .HB_CLKS  (HB_CLKS),
    .VFP_CLKS (VFP_CLKS)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .state_o  (state),
    .first_o  (cnt_first),
    .last_o   (cnt_last),
    .odd_o    (cnt_odd)
  );

  logic                 active, even_slot;
  logic [ByteWidth-1:0] data_q, data_d, lo_q, lo_d;
  logic                 vsync_q, href_q, sof_q, done_q, under_q, under_d;

  assign active    = (state == StActive);
  assign even_slot = active && !cnt_odd;
  // Ready depends only on the sequencer so upstream can't form a combinational loop.
  assign pix_ready = even_slot;

  always_comb begin
    data_d  = '0;
    lo_d    = lo_q;
    under_d = under_q;
    if (state == StVsync && cnt_first) under_d = 1'b0;
    if (even_slot) begin
      data_d = pix_valid ? pix_hi(pix_data) : '0;
      lo_d   = pix_valid ? pix_lo(pix_data) : '0;
      if (!pix_valid) under_d = 1'b1;
    end else if (active) begin
      data_d = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      data_q  <= '0;
      lo_q    <= '0;
    end else begin
      vsync_q <= (state == StVsync);
      href_q  <= active;
      sof_q   <= (state == StVsync) && cnt_first;
      done_q  <= (state == StVfp) && cnt_last;
      under_q <= under_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
    end
  end

  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_data   = data_q;
  assign pix_sof    = sof_q;
  assign frame_done = done_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Bench for cmos_dvp_tx: frame-position reference model checked every cycle, plus literal
// expectations for byte order, frame period, underrun, enable drop, reset and a 1x1 instance.
module tb_cmos_dvp_tx;

  localparam int H = 4, V = 2, VS = 2, VBP = 1, HB = 3, VFP = 1;
  localparam int L = 2 * H + HB;
  localparam int P = VS + VBP + V * L + VFP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready, pix_sof, dvp_vsync, dvp_href, frame_done, dvp_underrun;
  logic [7:0]  dvp_data;

  cmos_dvp_tx #(
    .H_PIXEL (H), .V_PIXEL (V), .VS_CLKS (VS), .VBP_CLKS (VBP), .HB_CLKS (HB), .VFP_CLKS (VFP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .dvp_vsync  (dvp_vsync),
    .dvp_href   (dvp_href),
    .dvp_data   (dvp_data),
    .frame_done (frame_done),
    .underrun   (dvp_underrun)
  );

  // Minimal geometry instance: 1x1 frame with single-clock blanking.
  logic        enable1 = 1'b1, valid1 = 1'b1;
  logic [15:0] data_in1 = 16'h1234;
  logic        ready1, sof1, vsync1, href1, done1, under1;
  logic [7:0]  data1;

  cmos_dvp_tx #(
    .H_PIXEL (1), .V_PIXEL (1), .VS_CLKS (1), .VBP_CLKS (1), .HB_CLKS (1), .VFP_CLKS (1)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable1),
    .pix_valid  (valid1),
    .pix_data   (data_in1),
    .pix_ready  (ready1),
    .pix_sof    (sof1),
    .dvp_vsync  (vsync1),
    .dvp_href   (href1),
    .dvp_data   (data1),
    .frame_done (done1),
    .underrun   (under1)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Where a frame-relative position falls: inside an href burst, and on an even byte slot.
  function automatic void slot(input int pos, output bit href, output bit even);
    int q;
    href = 0;
    even = 0;
    if (pos < 0) return;
    q = pos - VS - VBP;
    if (q >= 0 && q < V * L) begin
      href = (q % L) < 2 * H;
      even = ((q % L) % 2) == 0;
    end
  endfunction

  // Model: sp is the frame position the transmitter is working on (-1 = idle); the
  // registered outputs after an edge reflect the position held before that edge.
  int         sp = -1, cyc = 0;
  bit         uf = 0, rec = 0;
  logic [7:0] lat = '0;
  logic [7:0] hbytes[$];
  int         sof_cyc[$];

  always @(posedge clk) begin : model
    int op;
    bit h, e, h2, e2;
    logic [7:0] ed;
    logic pv;
    logic [15:0] pd;
    bit en;
    cyc++;
    pv = pix_valid;
    pd = pix_data;
    en = enable;
    if (!rst_n) begin
      sp = -1;
      uf = 0;
      lat = '0;
    end else begin
      op = sp;
      if (sp < 0 || sp == P - 1) sp = en ? 0 : -1;
      else sp++;
      slot(op, h, e);
      slot(sp, h2, e2);
      ed = '0;
      if (op == 0) uf = 0;
      if (h && e) begin
        ed  = pv ? pd[15:8] : 8'h00;
        lat = pv ? pd[7:0] : 8'h00;
        if (!pv) uf = 1;
      end else if (h) begin
        ed = lat;
      end
      #1;
      if (rst_n) begin
        chk("vsync", dvp_vsync, (op >= 0 && op < VS));
        chk("href", dvp_href, h);
        chk("data", dvp_data, ed);
        chk("sof", pix_sof, (op == 0));
        chk("done", frame_done, (op == P - 1));
        chk("underrun", dvp_underrun, uf);
        chk("ready", pix_ready, (h2 && e2));
        if (rec && dvp_href) hbytes.push_back(dvp_data);
        if (pix_sof) sof_cyc.push_back(cyc);
      end
    end
  end

  // Observations of the 1x1 instance.
  int         run1 = 0;
  int         runs1[$];
  int         sof1_cyc[$];
  logic [7:0] q1[$];

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (href1) begin
        run1++;
        if (q1.size() < 2) q1.push_back(data1);
      end else if (run1 != 0) begin
        runs1.push_back(run1);
        run1 = 0;
      end
      if (sof1) sof1_cyc.push_back(cyc);
    end
  end

  // Stimulus driver: inputs change on the falling edge only.
  int idx = 0, ready_cnt = 0, vmode = 0;
  bit acc = 0;

  task automatic tick();
    logic [7:0] hb, lb;
    @(negedge clk);
    if (acc) idx++;
    case (vmode)
      0:       pix_valid = 1'b1;
      1:       pix_valid = ($urandom_range(0, 3) != 0);
      default: pix_valid = !(pix_ready && ready_cnt == 2);
    endcase
    if (vmode == 1) begin
      pix_data = 16'($urandom);
    end else begin
      hb = 8'hA1 + 8'(34 * idx);
      lb = 8'hB2 + 8'(34 * idx);
      pix_data = {hb, lb};
    end
    if (pix_ready) ready_cnt++;
    acc = pix_valid && pix_ready;
  endtask

  task automatic wait_sof(input string name);
    for (int i = 0; i < 4 * P && !pix_sof; i++) tick();
    chk(name, pix_sof, 1'b1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4 * P && !frame_done; i++) tick();
    chk(name, frame_done, 1'b1);
  endtask

  task automatic wait_href(input string name);
    for (int i = 0; i < 4 * P && !dvp_href; i++) tick();
    chk(name, dvp_href, 1'b1);
  endtask

  logic [7:0] exp_b[6];
  int nsof;

  initial begin
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    rst_n = 1'b0;
    enable = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_vsync", dvp_vsync, 1'b0);
    chk("rst_href", dvp_href, 1'b0);
    chk("rst_data", dvp_data, 8'h00);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_underrun", dvp_underrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_vsync", dvp_vsync, 1'b0);

    // Continuous valid pixels: byte order, burst length and frame period.
    rec = 1;
    enable = 1'b1;
    repeat (2 * P + 4) tick();
    rec = 0;
    chk("href_bytes_2frames", hbytes.size(), 32);
    for (int i = 0; i < 6; i++)
      chk($sformatf("byte%0d", i), (hbytes.size() > i) ? 32'(hbytes[i]) : 32'hdead,
          32'(exp_b[i]));
    chk("frame_period", (sof_cyc.size() >= 2) ? sof_cyc[1] - sof_cyc[0] : -1, 26);

    // One missing pixel: underrun until the next frame start.
    wait_sof("sof_before_gap");
    vmode = 2;
    ready_cnt = 0;
    wait_done("done_after_gap");
    chk("underrun_set", dvp_underrun, 1'b1);
    vmode = 0;
    wait_sof("sof_after_gap");
    chk("underrun_clear", dvp_underrun, 1'b0);

    // Random valid/data over several frames.
    vmode = 1;
    repeat (3 * P) tick();
    vmode = 0;

    // Enable dropped during the first line: the frame finishes, then idle.
    wait_sof("sof_before_drop");
    wait_href("href_before_drop");
    enable = 1'b0;
    nsof = sof_cyc.size();
    wait_done("done_after_drop");
    repeat (3 * P) tick();
    chk("no_vsync_after_drop", sof_cyc.size(), nsof);
    chk("idle_href", dvp_href, 1'b0);
    chk("idle_data", dvp_data, 8'h00);

    // Asynchronous reset in the middle of a line.
    enable = 1'b1;
    wait_href("href_before_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vsync", dvp_vsync, 1'b0);
    chk("arst_href", dvp_href, 1'b0);
    chk("arst_data", dvp_data, 8'h00);
    chk("arst_ready", pix_ready, 1'b0);
    chk("arst_underrun", dvp_underrun, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("sof_after_rst", pix_sof, 1'b1);
    chk("vsync_after_rst", dvp_vsync, 1'b1);
    repeat (P) tick();

    // 1x1 geometry.
    chk("h1_href_run", (runs1.size() > 0) ? runs1[0] : -1, 2);
    chk("h1_period", (sof1_cyc.size() >= 2) ? sof1_cyc[1] - sof1_cyc[0] : -1, 6);
    chk("h1_byte0", (q1.size() > 0) ? 32'(q1[0]) : 32'hdead, 8'h12);
    chk("h1_byte1", (q1.size() > 1) ? 32'(q1[1]) : 32'hdead, 8'h34);
    chk("h1_underrun", under1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
